uart_dbg_tx: RTL and testbench
==============================

Name: uart_dbg_tx

Overview:
- 8N1 UART transmitter driving the board-level `uart_*_dbg_tx` pins. It is the transmit-side counterpart of the SoC debug UART receive path.
- Bytes are accepted on a valid/ready interface into a small FIFO, then serialized LSB-first at a fixed bit period.
- Sits in the `sys_clk` domain, between SoC/debug logic and the FPGA pin.

Parameters:
- CLKS_PER_BIT, 434, `sys_clk` cycles per UART bit (50 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 16, byte entries in the transmit FIFO. Must be a power of 2 and >= 2.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- i_data  input  8  byte to transmit
- i_valid  input  1  i_data valid
- o_ready  output  1  FIFO can accept a byte; equals (fifo_count < FIFO_DEPTH)
- o_tx  output  1  serial line; idle high; registered output
- o_busy  output  1  high while a frame is on the line (START, DATA or STOP state)
- o_idle  output  1  FIFO empty and state IDLE
- o_fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently held in the FIFO (excludes the byte in the shifter)

Behaviour:
- Reset, asynchronous on `sys_rst_n` low:
  - o_tx=1, o_busy=0, o_idle=1, o_fifo_count=0, o_ready=1.
  - FIFO pointers cleared; state IDLE; baud and bit counters 0.
  - Applies immediately, including mid-frame. The partial frame is abandoned and the FIFO contents are discarded.
- Push: on an edge with i_valid && o_ready, i_data is written at the write pointer and the write pointer increments, wrapping modulo FIFO_DEPTH.
  - i_valid while o_ready=0 is ignored, with no side effects.
  - i_data is don't-care when i_valid=0.
- Pop: on an edge where the state is IDLE, or STOP on its final cycle, and the FIFO is non-empty:
  - The head byte loads into the shift register and the read pointer increments.
  - The state goes to START and o_tx is driven 0 from that edge.
- No FIFO bypass: a byte pushed into an empty FIFO at edge N is popped at edge N+1. o_tx therefore falls at edge N+1, one cycle after acceptance.
- Push and pop on the same edge leave the count unchanged. A push into a full FIFO cannot occur because o_ready gates it.
- State machine (baud counter counts 0..CLKS_PER_BIT-1; the bit ends when it reaches CLKS_PER_BIT-1):
  - IDLE: o_tx=1. Go to START on pop.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_tx = shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7 (LSB first). After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty, pop and go directly to START, with zero extra idle cycles between frames.
    - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are gapless.
- Counter widths: baud counter $clog2(CLKS_PER_BIT) bits; bit index 3 bits. All counters wrap explicitly and never overflow.
- o_busy=1 exactly in START, DATA and STOP.
- o_idle = (state==IDLE) && (fifo_count==0).
- o_ready drops combinationally from the count only, never from the state.

Test Plan:
- Reset, then 100 idle cycles -> o_tx=1, o_busy=0, o_idle=1, o_ready=1, o_fifo_count=0 throughout.
- CLKS_PER_BIT=4: push 0xA5 at edge N:
  - o_tx=0 over edges N+1..N+4.
  - Data bits 1,0,1,0,0,1,0,1, each lasting 4 cycles.
  - Stop=1 for 4 cycles.
  - o_busy high for exactly 40 cycles, then o_idle=1.
- CLKS_PER_BIT=4: push 0x00, 0xFF, 0x3C on consecutive cycles -> three frames spanning 120 cycles with no high gap between one stop bit and the next start bit; the bench UART model decodes 0x00, 0xFF, 0x3C in order.
- FIFO_DEPTH=16, i_valid held high with incrementing data starting at 0x00 -> 17 bytes accepted (1 in the shifter plus 16 in the FIFO). o_ready=0 with o_fifo_count=16, and it rises for one accept per completed pop. All bytes are decoded in order with none dropped or duplicated.
- Reset asserted mid-DATA with 5 bytes queued -> o_tx=1 within the same cycle and o_fifo_count=0. After release, o_tx stays high with no residual frame. A fresh push of 0x55 decodes correctly.
- Random i_valid with CLKS_PER_BIT=2, 1000 bytes -> the scoreboard matches all bytes, and o_fifo_count never exceeds 16 and never underflows.

Source files
------------

// File: rtl/uart_dbg_tx.sv
// 8N1 debug UART transmitter: valid/ready byte input into a small FIFO,
// serialized LSB-first at CLKS_PER_BIT clocks per bit with gapless back-to-back frames.
module uart_dbg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic [7:0]                           i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic                                 o_tx,
  output logic                                 o_busy,
  output logic                                 o_idle,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  state_t        w_state_next;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign o_ready   = (r_count != FIFO_FULL);
  assign w_push    = i_valid && o_ready;
  assign w_bit_end = (r_baud == BAUD_LAST);
  // The shifter is reloaded either from IDLE or on the last STOP cycle, so frames abut.
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // Line level is computed for the next state so o_tx stays a plain register.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (w_pop) begin
          w_state_next = S_START;
          w_shift_next = w_head;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_shift[r_bit + 3'd1];
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (w_pop) begin
            w_state_next = S_START;
            w_shift_next = w_head;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_idle       = (r_state == S_IDLE) && (r_count == '0);
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_uart_dbg_tx.sv
// Bench for uart_dbg_tx: directed frames on a 4-clock/bit instance, random traffic on a
// 2-clock/bit instance; a line decoder pops expected bytes from a scoreboard queue.
module tb_uart_dbg_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;
  logic       sel;
  logic       acc;

  logic       vld4, rdy4, tx4, busy4, idle4;
  logic [4:0] cnt4;
  logic       vld2, rdy2, tx2, busy2, idle2;
  logic [4:0] cnt2;

  logic       rdy, tx, busy, idle;
  logic [4:0] cnt;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign vld4 = vld && !sel;
  assign vld2 = vld && sel;
  assign rdy  = sel ? rdy2  : rdy4;
  assign tx   = sel ? tx2   : tx4;
  assign busy = sel ? busy2 : busy4;
  assign idle = sel ? idle2 : idle4;
  assign cnt  = sel ? cnt2  : cnt4;

  uart_dbg_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .i_data(din), .i_valid(vld4),
    .o_ready(rdy4), .o_tx(tx4), .o_busy(busy4), .o_idle(idle4), .o_fifo_count(cnt4)
  );

  uart_dbg_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(16)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .i_data(din), .i_valid(vld2),
    .o_ready(rdy2), .o_tx(tx2), .o_busy(busy2), .o_idle(idle2), .o_fifo_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, output logic a);
    vld = v;
    din = d;
    a   = v && rdy;
    @(posedge clk);
    if (a) exp_q.push_back(d);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    logic a;
    int   n = 0;
    while (!(idle && exp_q.size() == 0) && n < max_cycles) begin
      cyc(1'b0, 8'h00, a);
      n++;
    end
    chk("wait_idle_timeout", 32'(n < max_cycles), 32'd1);
    chk("wait_idle_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Line decoder: counts falling-edge samples from the start bit and samples mid-bit.
  initial begin : monitor
    int         s;
    int         cpb;
    logic       active;
    logic [7:0] rx;
    logic [7:0] e;
    active = 1'b0;
    s      = 0;
    rx     = 8'h00;
    forever begin
      @(negedge clk);
      cpb = sel ? 2 : 4;
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          if (tx === 1'b0) begin
            active = 1'b1;
            s      = 0;
          end
        end else begin
          s++;
        end
        if (active) begin
          if (s == cpb / 2) chk("rx_start_bit", 32'(tx), 32'd0);
          for (int k = 0; k < 8; k++)
            if (s == cpb * (k + 1) + cpb / 2) rx[k] = tx;
          if (s == 9 * cpb + cpb / 2) chk("rx_stop_bit", 32'(tx), 32'd1);
          if (s == 10 * cpb - 1) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rx_unexpected_frame: got 0x%0h, expected no frame", rx);
            end else begin
              e = exp_q.pop_front();
              chk("rx_byte", 32'(rx), 32'(e));
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [9:0] fr;
    logic [7:0] d;
    int         nacc;
    int         n;

    rst_n = 1'b0;
    sel   = 1'b0;
    vld   = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({tx, busy, idle, rdy, cnt}), 32'(9'b1_0_1_1_00000));
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 8'h00, acc);
      chk("idle_outputs", 32'({tx, busy, idle, rdy, cnt}), 32'(9'b1_0_1_1_00000));
    end

    // 0xA5: start, 1,0,1,0,0,1,0,1 LSB first, stop
    fr = 10'b1_10100101_0;
    cyc(1'b1, 8'hA5, acc);
    chk("a5_accept", 32'(acc), 32'd1);
    chk("a5_no_bypass_tx", 32'(tx), 32'd1);
    chk("a5_count", 32'(cnt), 32'd1);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 8'h00, acc);
      chk("a5_tx", 32'(tx), 32'(fr[k / 4]));
      chk("a5_busy", 32'(busy), 32'd1);
    end
    cyc(1'b0, 8'h00, acc);
    chk("a5_done", 32'({busy, idle, tx}), 32'(3'b011));

    // 0x00, 0xFF, 0x3C back to back
    cyc(1'b1, 8'h00, acc);
    chk("b2b_accept0", 32'(acc), 32'd1);
    chk("b2b_first_tx", 32'(tx), 32'd1);
    for (int k = 1; k <= 120; k++) begin
      if (k == 1) begin
        cyc(1'b1, 8'hFF, acc);
        chk("b2b_accept1", 32'(acc), 32'd1);
      end else if (k == 2) begin
        cyc(1'b1, 8'h3C, acc);
        chk("b2b_accept2", 32'(acc), 32'd1);
      end else begin
        cyc(1'b0, 8'h00, acc);
      end
      chk("b2b_busy", 32'(busy), 32'd1);
      if (k == 1 || k == 41 || k == 81) chk("b2b_start_edge", 32'(tx), 32'd0);
      if (k == 40 || k == 80 || k == 120) chk("b2b_stop_end", 32'(tx), 32'd1);
    end
    cyc(1'b0, 8'h00, acc);
    chk("b2b_done", 32'({busy, idle}), 32'(2'b01));

    // FIFO fill with i_valid held high
    d    = 8'h00;
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, d, acc);
      if (acc) begin
        d++;
        nacc++;
      end
    end
    chk("fill_accepts", 32'(nacc), 32'd17);
    chk("fill_count", 32'(cnt), 32'd16);
    chk("fill_ready", 32'(rdy), 32'd0);
    n = 0;
    while (nacc < 20 && n < 300) begin
      if (rdy) chk("refill_ready_count", 32'(cnt), 32'd15);
      cyc(1'b1, d, acc);
      if (acc) begin
        d++;
        nacc++;
        chk("refill_count", 32'(cnt), 32'd16);
        chk("refill_ready_low", 32'(rdy), 32'd0);
      end
      n++;
    end
    chk("refill_accepts", 32'(nacc), 32'd20);
    wait_idle(2000);

    // Reset in the middle of a 0x00 data bit with five bytes queued
    cyc(1'b1, 8'h00, acc);
    cyc(1'b1, 8'h11, acc);
    cyc(1'b1, 8'h22, acc);
    cyc(1'b1, 8'h33, acc);
    cyc(1'b1, 8'h44, acc);
    cyc(1'b1, 8'h55, acc);
    repeat (6) cyc(1'b0, 8'h00, acc);
    chk("pre_reset_tx", 32'(tx), 32'd0);
    chk("pre_reset_count", 32'(cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({tx, busy, idle, rdy, cnt}), 32'(9'b1_0_1_1_00000));
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 8'h00, acc);
      chk("post_reset_quiet", 32'({tx, busy, cnt}), 32'(7'b1_0_00000));
    end
    cyc(1'b1, 8'h55, acc);
    chk("post_reset_accept", 32'(acc), 32'd1);
    wait_idle(200);

    // Random traffic on the 2-clock/bit instance
    sel = 1'b1;
    @(negedge clk);
    chk("rand_start_state", 32'({tx, busy, idle, rdy, cnt}), 32'(9'b1_0_1_1_00000));
    nacc = 0;
    n    = 0;
    while (nacc < 1000 && n < 60000) begin
      cyc(($urandom_range(0, 11) == 0), 8'($urandom), acc);
      if (acc) nacc++;
      chk("rand_count_max", 32'(cnt <= 5'd16), 32'd1);
      chk("rand_ready", 32'(rdy), 32'(cnt != 5'd16));
      n++;
    end
    chk("rand_accepts", 32'(nacc), 32'd1000);
    wait_idle(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
